// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline (load-use, MEM redirects, dmem wait with timeout)
module pipe_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int TO_W        = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_wreg,
  input  logic             mem_branch_taken,
  input  logic             mem_jump,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       pc_sel,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
  state_t          state, state_nx;
  logic [TO_W-1:0] timer, timer_nx;
  logic            busy, redir, lu, go, flush_ev, stall;
  assign busy  = dmem_req & ~dmem_ready;
  assign redir = mem_branch_taken | mem_jump;
  assign lu    = ex_memread & (|ex_wreg) & ((ex_wreg == id_rs) | (id_uses_rt & (ex_wreg == id_rt)));
  // go: the normal redirect/load-use/run rules apply this cycle
  assign go    = RST_N & (((state == RUN) & ~busy) | ((state == MEM_WAIT) & dmem_ready));
  always_ff @(negedge CLK or negedge RST_N)
    if (!RST_N) begin
      state     <= RUN;
      timer     <= '0;
      err       <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      err   <= err | (state_nx == ERROR);
      if (!pc_en && ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
      if (flush_ev && ~&flush_cnt) flush_cnt <= flush_cnt + 1'b1;
    end
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    if (state == RUN && busy) begin
      state_nx = MEM_WAIT;
      timer_nx = TO_W'(1);
    end else if (state == MEM_WAIT && dmem_ready) begin
      state_nx = RUN;
      timer_nx = '0;
    end else if (state == MEM_WAIT) begin
      timer_nx = timer + 1'b1;
      state_nx = (timer == TO_W'(MEM_TIMEOUT - 1)) ? ERROR : MEM_WAIT;
    end
  end
  always_comb begin
    flush_ev    = go & redir;
    stall       = go & ~redir & lu;
    pc_en       = go & ~stall;
    ifid_en     = go & ~stall;
    idex_en     = go;
    exmem_en    = go;
    memwb_en    = go;
    ifid_flush  = ~RST_N | flush_ev;
    idex_flush  = ~RST_N | flush_ev | stall;
    exmem_flush = ~RST_N | flush_ev;
    pc_sel      = !flush_ev ? 2'd0 : mem_jump ? 2'd2 : 2'd1;
  end
endmodule
